multicycle_control_fsm: RTL and testbench
=========================================

Name: multicycle_control_fsm

Overview:
Multi-cycle MIPS control sequencer. It replaces the single-cycle decoder when the datapath is shared across cycles: one ALU, one unified memory, plus IR/MDR/A/B/ALUOut registers. A Moore FSM steps each instruction through fetch, decode, execute, memory and writeback, and stalls on a memory-ready handshake. It also counts retired instructions.

Parameters:
CNT_W, 32, width of retired-instruction counter instr_count.

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
opcode  input  6  IR[31:26]; valid from DECODE onward
mem_ready  input  1  memory completes the current read/write this cycle
PCWrite  output  1  unconditional PC load
PCWriteCond  output  1  PC load if ALU zero (BEQ)
PCSrc  output  2  00 ALU result, 01 ALUOut, 10 jump target
IorD  output  1  memory address: 0 PC, 1 ALUOut
MemRead  output  1  memory read strobe
MemWrite  output  1  memory write strobe
IRWrite  output  1  load IR from memory data
MemtoReg  output  1  writeback source: 0 ALUOut, 1 MDR
RegDst  output  1  dest register: 0 rt, 1 rd
RegWrite  output  1  register file write enable
ALUSrcA  output  1  0 PC, 1 A
ALUSrcB  output  2  00 B, 01 constant 4, 10 sign-ext imm, 11 sign-ext imm<<2
ALUOp  output  2  00 add, 01 sub, 10 funct-decoded
state  output  4  current state encoding (debug)
instr_count  output  CNT_W  retired instructions, wraps modulo 2^CNT_W

Behaviour:
- Single clock domain.
- Reset is synchronous and active-high. On reset: state=FETCH(0), instr_count=0. Reset overrides all transitions, including mid-instruction and mid-stall.
- Every output not listed as asserted for a state is 0.
- Outputs depend on state only, except PCWrite/IRWrite in FETCH, which are gated by mem_ready.
- States (encoding: outputs asserted -> next state):
  FETCH 0: MemRead, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00; IRWrite=PCWrite=mem_ready -> DECODE if mem_ready, else hold FETCH.
  DECODE 1: ALUSrcA=0, ALUSrcB=11, ALUOp=00 -> by opcode:
    000000 -> EXEC
    100011 or 101011 -> MEMADR
    000100 -> BEQ
    000010 -> JUMP
    001000 -> ADDIEX
    other -> illegal handling (see Optional Feature)
  MEMADR 2: ALUSrcA=1, ALUSrcB=10, ALUOp=00 -> MEMRD if opcode=100011, else MEMWR.
  MEMRD 3: MemRead, IorD=1 -> MEMWB if mem_ready, else hold.
  MEMWB 4: RegWrite, MemtoReg=1, RegDst=0 -> FETCH.
  MEMWR 5: MemWrite, IorD=1 -> FETCH if mem_ready, else hold.
  EXEC 6: ALUSrcA=1, ALUSrcB=00, ALUOp=10 -> RWB.
  RWB 7: RegWrite, RegDst=1, MemtoReg=0 -> FETCH.
  BEQ 8: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond, PCSrc=01 -> FETCH.
  JUMP 9: PCWrite, PCSrc=10 -> FETCH.
  ADDIEX 10: ALUSrcA=1, ALUSrcB=10, ALUOp=00 -> ADDIWB.
  ADDIWB 11: RegWrite, RegDst=0, MemtoReg=0 -> FETCH.
  Codes 12-15 unused; any unused code -> FETCH next cycle with all outputs 0 (12 is used only as TRAP when the optional feature is enabled).
- Latency with mem_ready held high: R/addi 4 cycles, LW 5, SW 4, BEQ 3, J 3. Each cycle mem_ready is low in FETCH/MEMRD/MEMWR adds one cycle. Strobes stay asserted and stable during a stall.
- opcode is sampled in DECODE and MEMADR only; changes in other states are ignored.
- instr_count increments by 1 on the clock edge leaving MEMWB, MEMWR (with mem_ready), RWB, BEQ, JUMP or ADDIWB to FETCH.
- instr_count wraps from all-ones to 0. Reset takes priority over an increment in the same cycle.

Optional Feature:
Macro: ILLEGAL_OPCODE_TRAP_EN.
- Defined: adds output illegal_op (1 bit) and state TRAP 12. An unlisted opcode in DECODE -> TRAP. In TRAP, illegal_op=1, all other outputs 0, state held until reset. instr_count does not increment.
- Undefined: unlisted opcode in DECODE -> FETCH as a NOP. instr_count does not increment. No illegal_op port.

Test Plan:
- Reset, then opcode=000000 with mem_ready=1 -> state sequence 0,1,6,7,0; RegWrite=1, RegDst=1 only in state 7; instr_count=1.
- LW (100011), mem_ready low for 2 cycles in MEMRD -> state 3 held 3 cycles with MemRead=1, IorD=1; then 4 with MemtoReg=1, RegWrite=1; total 7 cycles; instr_count increments once.
- BEQ (000100) then J (000010), mem_ready=1 -> state 8 with PCWriteCond=1, PCSrc=01, ALUOp=01; state 9 with PCWrite=1, PCSrc=10; instr_count=2 after 6 cycles.
- SW (101011), reset asserted while in MEMWR with mem_ready=0 -> next cycle state=0, MemWrite=0, instr_count=0.
- CNT_W=4, sixteen J instructions -> instr_count goes 15 then 0; addi (001000) -> states 10,11 with RegWrite=1 in 11, RegDst=0.
- opcode=111111 -> with ILLEGAL_OPCODE_TRAP_EN: state 12, illegal_op=1 held 10 cycles, cleared by reset; without the macro: returns to state 0, instr_count unchanged.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle MIPS control sequencer: Moore FSM driving a shared ALU/memory datapath.
// Optional macro ILLEGAL_OPCODE_TRAP_EN adds a sticky TRAP state and the illegal_op output.
module multicycle_control_fsm #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic [1:0]       PCSrc,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
`ifdef ILLEGAL_OPCODE_TRAP_EN
  output logic             illegal_op,
`endif
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BEQ    = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
    S_TRAP   = 4'd12
  } state_e;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_src;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // Control word for a state; FETCH's PCWrite/IRWrite are added later from mem_ready.
  function automatic ctrl_t decode_ctrl(input state_e s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH:  begin c.mem_read = 1'b1; c.alu_src_b = 2'b01; end
      S_DECODE: c.alu_src_b = 2'b11;
      S_MEMADR: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      S_MEMRD:  begin c.mem_read = 1'b1; c.iord = 1'b1; end
      S_MEMWB:  begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
      S_MEMWR:  begin c.mem_write = 1'b1; c.iord = 1'b1; end
      S_EXEC:   begin c.alu_src_a = 1'b1; c.alu_op = 2'b10; end
      S_RWB:    begin c.reg_write = 1'b1; c.reg_dst = 1'b1; end
      S_BEQ:    begin
        c.alu_src_a = 1'b1; c.alu_op = 2'b01;
        c.pc_write_cond = 1'b1; c.pc_src = 2'b01;
      end
      S_JUMP:   begin c.pc_write = 1'b1; c.pc_src = 2'b10; end
      S_ADDIEX: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      S_ADDIWB: c.reg_write = 1'b1;
      default:  c = '0;
    endcase
    return c;
  endfunction

  state_e           state_q, state_d;
  ctrl_t            ctrl_q, ctrl_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             retire;

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:      state_d = S_EXEC;
          OP_LW, OP_SW:  state_d = S_MEMADR;
          OP_BEQ:        state_d = S_BEQ;
          OP_J:          state_d = S_JUMP;
          OP_ADDI:       state_d = S_ADDIEX;
`ifdef ILLEGAL_OPCODE_TRAP_EN
          default:       state_d = S_TRAP;
`else
          default:       state_d = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:  begin state_d = S_FETCH; retire = 1'b1; end
      S_MEMWR:  if (mem_ready) begin state_d = S_FETCH; retire = 1'b1; end
      S_EXEC:   state_d = S_RWB;
      S_RWB:    begin state_d = S_FETCH; retire = 1'b1; end
      S_BEQ:    begin state_d = S_FETCH; retire = 1'b1; end
      S_JUMP:   begin state_d = S_FETCH; retire = 1'b1; end
      S_ADDIEX: state_d = S_ADDIWB;
      S_ADDIWB: begin state_d = S_FETCH; retire = 1'b1; end
`ifdef ILLEGAL_OPCODE_TRAP_EN
      S_TRAP:   state_d = S_TRAP;
`endif
      default:  state_d = S_FETCH;
    endcase
    cnt_d  = retire ? cnt_q + {{(CNT_W-1){1'b0}}, 1'b1} : cnt_q;
    ctrl_d = decode_ctrl(state_d);
  end

  // Outputs are registered by decoding the next state, so they line up with state_q.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
      ctrl_q  <= decode_ctrl(S_FETCH);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctrl_q  <= ctrl_d;
    end
  end

`ifdef ILLEGAL_OPCODE_TRAP_EN
  logic illegal_q;
  always_ff @(posedge clk) begin
    if (reset) illegal_q <= 1'b0;
    else       illegal_q <= (state_d == S_TRAP);
  end
  assign illegal_op = illegal_q;
`endif

  assign PCWrite     = ctrl_q.pc_write | ((state_q == S_FETCH) & mem_ready);
  assign IRWrite     = (state_q == S_FETCH) & mem_ready;
  assign PCWriteCond = ctrl_q.pc_write_cond;
  assign PCSrc       = ctrl_q.pc_src;
  assign IorD        = ctrl_q.iord;
  assign MemRead     = ctrl_q.mem_read;
  assign MemWrite    = ctrl_q.mem_write;
  assign MemtoReg    = ctrl_q.mem_to_reg;
  assign RegDst      = ctrl_q.reg_dst;
  assign RegWrite    = ctrl_q.reg_write;
  assign ALUSrcA     = ctrl_q.alu_src_a;
  assign ALUSrcB     = ctrl_q.alu_src_b;
  assign ALUOp       = ctrl_q.alu_op;
  assign state       = state_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm, built with a 4-bit counter to reach the wrap.
module tb_multicycle_control_fsm;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [5:0]       opcode;
  logic             mem_ready;
  logic             PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic             MemtoReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0]       PCSrc, ALUSrcB, ALUOp;
  logic [3:0]       state;
  logic [CNT_W-1:0] instr_count;
`ifdef ILLEGAL_OPCODE_TRAP_EN
  logic             illegal_op;
`endif

  int n_cmp = 0;
  int n_err = 0;

  multicycle_control_fsm #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCSrc(PCSrc), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg),
    .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp),
`ifdef ILLEGAL_OPCODE_TRAP_EN
    .illegal_op(illegal_op),
`endif
    .state(state), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; mem_ready = 1'b0; opcode = 6'd0;
    step(); step();
    reset = 1'b0;
    #1;
    n_cmp++; if (state !== 4'd0) begin n_err++; $display("FAIL reset_state got %0d want 0", state); end
    n_cmp++; if (instr_count !== 4'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", instr_count); end
    n_cmp++; if ({MemRead, IorD, ALUSrcB, PCWrite, IRWrite, RegWrite} !== 7'b1001000)
      begin n_err++; $display("FAIL reset_fetch_ctrl got %b want 1001000", {MemRead, IorD, ALUSrcB, PCWrite, IRWrite, RegWrite}); end
  endtask

  task automatic test_fetch_stall();
    step();
    n_cmp++; if (state !== 4'd0 || IRWrite !== 1'b0 || PCWrite !== 1'b0)
      begin n_err++; $display("FAIL fetch_stall got st=%0d ir=%b pc=%b want 0,0,0", state, IRWrite, PCWrite); end
    mem_ready = 1'b1;
    #1;
    n_cmp++; if (IRWrite !== 1'b1 || PCWrite !== 1'b1)
      begin n_err++; $display("FAIL fetch_ready got ir=%b pc=%b want 1,1", IRWrite, PCWrite); end
  endtask

  task automatic test_rtype();
    logic [3:0] seq [4];
    logic [3:0] want [4] = '{4'd1, 4'd6, 4'd7, 4'd0};
    opcode = 6'b000000; mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(); seq[i] = state;
      if (state == 4'd6) begin
        n_cmp++; if (RegWrite !== 1'b0) begin n_err++; $display("FAIL rtype_exec_regwrite got %b want 0", RegWrite); end
      end
      if (state == 4'd7) begin
        n_cmp++; if (RegWrite !== 1'b1 || RegDst !== 1'b1)
          begin n_err++; $display("FAIL rtype_rwb got rw=%b rd=%b want 1,1", RegWrite, RegDst); end
      end
    end
    n_cmp++; if (seq !== want) begin n_err++; $display("FAIL rtype_seq got %0d %0d %0d %0d want 1 6 7 0", seq[0], seq[1], seq[2], seq[3]); end
    n_cmp++; if (instr_count !== 4'd1) begin n_err++; $display("FAIL rtype_count got %0d want 1", instr_count); end
  endtask

  task automatic test_lw_stall();
    int cyc = 0;
    int held = 0;
    opcode = 6'b100011; mem_ready = 1'b1;
    step(); step(); step(); cyc = 3;
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) mem_ready = 1'b1;
      #1;
      if (state == 4'd3) held++;
      n_cmp++; if (state !== 4'd3 || MemRead !== 1'b1 || IorD !== 1'b1)
        begin n_err++; $display("FAIL lw_memrd[%0d] got st=%0d mr=%b iord=%b want 3,1,1", i, state, MemRead, IorD); end
      step(); cyc++;
    end
    n_cmp++; if (state !== 4'd4 || MemtoReg !== 1'b1 || RegWrite !== 1'b1)
      begin n_err++; $display("FAIL lw_memwb got st=%0d m2r=%b rw=%b want 4,1,1", state, MemtoReg, RegWrite); end
    n_cmp++; if (instr_count !== 4'd1) begin n_err++; $display("FAIL lw_count_early got %0d want 1", instr_count); end
    step(); cyc++;
    n_cmp++; if (state !== 4'd0 || cyc !== 7 || held !== 3)
      begin n_err++; $display("FAIL lw_total got st=%0d cyc=%0d held=%0d want 0,7,3", state, cyc, held); end
    n_cmp++; if (instr_count !== 4'd2) begin n_err++; $display("FAIL lw_count got %0d want 2", instr_count); end
  endtask

  task automatic test_beq_jump();
    mem_ready = 1'b1; opcode = 6'b000100;
    step(); step();
    n_cmp++; if (state !== 4'd8 || PCWriteCond !== 1'b1 || PCSrc !== 2'b01 || ALUOp !== 2'b01 || PCWrite !== 1'b0)
      begin n_err++; $display("FAIL beq got st=%0d pwc=%b src=%b op=%b pw=%b want 8,1,01,01,0", state, PCWriteCond, PCSrc, ALUOp, PCWrite); end
    step(); opcode = 6'b000010;
    step(); step();
    n_cmp++; if (state !== 4'd9 || PCWrite !== 1'b1 || PCSrc !== 2'b10 || PCWriteCond !== 1'b0)
      begin n_err++; $display("FAIL jump got st=%0d pw=%b src=%b pwc=%b want 9,1,10,0", state, PCWrite, PCSrc, PCWriteCond); end
    step();
    n_cmp++; if (state !== 4'd0 || instr_count !== 4'd4)
      begin n_err++; $display("FAIL beq_j_count got st=%0d cnt=%0d want 0,4", state, instr_count); end
  endtask

  task automatic test_sw_reset();
    mem_ready = 1'b1; opcode = 6'b101011;
    step(); step(); step();
    mem_ready = 1'b0; opcode = 6'b100011;
    step();
    n_cmp++; if (state !== 4'd5 || MemWrite !== 1'b1 || IorD !== 1'b1 || instr_count !== 4'd4)
      begin n_err++; $display("FAIL sw_stall got st=%0d mw=%b iord=%b cnt=%0d want 5,1,1,4", state, MemWrite, IorD, instr_count); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_cmp++; if (state !== 4'd0 || MemWrite !== 1'b0 || instr_count !== 4'd0)
      begin n_err++; $display("FAIL sw_reset got st=%0d mw=%b cnt=%0d want 0,0,0", state, MemWrite, instr_count); end
  endtask

  task automatic test_count_wrap();
    mem_ready = 1'b1; opcode = 6'b000010;
    for (int i = 0; i < 16; i++) begin
      step(); step(); step();
      if (i == 14) begin
        n_cmp++; if (instr_count !== 4'd15) begin n_err++; $display("FAIL wrap_15 got %0d want 15", instr_count); end
      end
    end
    n_cmp++; if (instr_count !== 4'd0 || state !== 4'd0)
      begin n_err++; $display("FAIL wrap_0 got cnt=%0d st=%0d want 0,0", instr_count, state); end
  endtask

  task automatic test_addi();
    mem_ready = 1'b1; opcode = 6'b001000;
    step(); step();
    n_cmp++; if (state !== 4'd10 || ALUSrcA !== 1'b1 || ALUSrcB !== 2'b10 || RegWrite !== 1'b0)
      begin n_err++; $display("FAIL addi_ex got st=%0d sa=%b sb=%b rw=%b want 10,1,10,0", state, ALUSrcA, ALUSrcB, RegWrite); end
    step();
    n_cmp++; if (state !== 4'd11 || RegWrite !== 1'b1 || RegDst !== 1'b0 || MemtoReg !== 1'b0)
      begin n_err++; $display("FAIL addi_wb got st=%0d rw=%b rd=%b m2r=%b want 11,1,0,0", state, RegWrite, RegDst, MemtoReg); end
    step();
    n_cmp++; if (state !== 4'd0 || instr_count !== 4'd1)
      begin n_err++; $display("FAIL addi_done got st=%0d cnt=%0d want 0,1", state, instr_count); end
  endtask

  task automatic test_illegal();
    mem_ready = 1'b1; opcode = 6'b111111;
    step(); step();
`ifdef ILLEGAL_OPCODE_TRAP_EN
    for (int i = 0; i < 10; i++) begin
      n_cmp++; if (state !== 4'd12 || illegal_op !== 1'b1 || MemRead !== 1'b0 || PCWrite !== 1'b0)
        begin n_err++; $display("FAIL trap[%0d] got st=%0d ill=%b mr=%b pw=%b want 12,1,0,0", i, state, illegal_op, MemRead, PCWrite); end
      step();
    end
    n_cmp++; if (instr_count !== 4'd1) begin n_err++; $display("FAIL trap_count got %0d want 1", instr_count); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_cmp++; if (state !== 4'd0 || illegal_op !== 1'b0)
      begin n_err++; $display("FAIL trap_reset got st=%0d ill=%b want 0,0", state, illegal_op); end
`else
    n_cmp++; if (state !== 4'd0 || instr_count !== 4'd1 || MemRead !== 1'b1)
      begin n_err++; $display("FAIL illegal_nop got st=%0d cnt=%0d mr=%b want 0,1,1", state, instr_count, MemRead); end
`endif
  endtask

  initial begin
    test_reset();
    test_fetch_stall();
    test_rtype();
    test_lw_stall();
    test_beq_jump();
    test_sw_reset();
    test_count_wrap();
    test_addi();
    test_illegal();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
